// File: rtl/mebra_pkg.sv
// Shared widths and mode encoding for the pixel beamformer core.
package mebra_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int OUT_W     = 17;
    localparam int DAS_ACC_W = 23;
    localparam int ROOT_W    = 9;
    localparam int SUM_W     = 16;
    localparam int SQ_W      = 22;
    localparam int D_W       = 32;

    typedef enum logic {
        MODE_DAS  = 1'b0,
        MODE_DMAS = 1'b1
    } mode_e;
endpackage

// File: rtl/isqrt_pipe.sv
// Pipelined floor integer square root (digit-by-digit), iterations spread
// over LATENCY register stages; result appears LATENCY edges after the input edge.
module isqrt_pipe #(
    parameter int IN_W    = 16,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   i_x,
    output logic [IN_W/2-1:0] o_root
);
    localparam int ITERS = IN_W / 2;
    localparam int RT_W  = IN_W / 2;
    localparam int REM_W = RT_W + 2;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        localparam int LO = (s * ITERS) / LATENCY;
        localparam int HI = ((s + 1) * ITERS) / LATENCY;

        logic [IN_W-1:0]  w_x_in;
        logic [REM_W-1:0] w_rem_in;
        logic [RT_W-1:0]  w_root_in;
        logic [IN_W-1:0]  w_x;
        logic [REM_W-1:0] w_rem;
        logic [RT_W-1:0]  w_root;
        logic [IN_W-1:0]  r_x;
        logic [REM_W-1:0] r_rem;
        logic [RT_W-1:0]  r_root;

        if (s == 0) begin : g_first
            assign w_x_in    = i_x;
            assign w_rem_in  = '0;
            assign w_root_in = '0;
        end else begin : g_next
            assign w_x_in    = g_stage[s-1].r_x;
            assign w_rem_in  = g_stage[s-1].r_rem;
            assign w_root_in = g_stage[s-1].r_root;
        end

        // Each iteration brings down the next two input bits and tries a 1 root digit.
        always_comb begin
            w_x    = w_x_in;
            w_rem  = w_rem_in;
            w_root = w_root_in;
            for (int i = LO; i < HI; i++) begin
                w_rem = {w_rem[REM_W-3:0], w_x[IN_W-1 -: 2]};
                w_x   = {w_x[IN_W-3:0], 2'b00};
                if (w_rem >= {w_root, 2'b01}) begin
                    w_rem  = w_rem - {w_root, 2'b01};
                    w_root = {w_root[RT_W-2:0], 1'b1};
                end else begin
                    w_root = {w_root[RT_W-2:0], 1'b0};
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_x    <= '0;
                r_rem  <= '0;
                r_root <= '0;
            end else begin
                r_x    <= w_x;
                r_rem  <= w_rem;
                r_root <= w_root;
            end
        end
    end

    logic w_unused_tail;
    assign w_unused_tail = ^{g_stage[LATENCY-1].r_x, g_stage[LATENCY-1].r_rem};
    assign o_root = g_stage[LATENCY-1].r_root;
endmodule

// File: rtl/mebra_core.sv
// Single-pixel receive beamformer: DAS channel mean or multiplier-free DMAS
// via signed square roots, one result loaded at a fixed edge per frame.
module mebra_core
    import mebra_pkg::*;
#(
    parameter int channels     = 128,
    parameter int bit_size     = 8,
    parameter int pixels       = 1,
    parameter int datasize     = channels,
    parameter int sqrt_latency = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic signed [SAMPLE_W-1:0] rfdata,
    output logic signed [OUT_W-1:0]    bf_out
);
    localparam int L     = sqrt_latency;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] C_LAST_SAMPLE = CNT_W'(channels);
    localparam logic [CNT_W-1:0] C_ACC_FIRST   = CNT_W'(L + 2);
    localparam logic [CNT_W-1:0] C_ACC_LAST    = CNT_W'(channels + L + 1);
    localparam logic [CNT_W-1:0] C_COMBINE     = CNT_W'(channels + L + 2);
    localparam logic [CNT_W-1:0] C_LOAD        = CNT_W'(channels + 2 * L + 3);

    logic [CNT_W-1:0]           r_cnt;
    mode_e                      r_mode;
    logic signed [DAS_ACC_W-1:0] r_das_acc;
    logic [SAMPLE_W-1:0]        r_abs;
    logic                       r_neg;
    logic [L-1:0]               r_sgn_dly;
    logic signed [SUM_W-1:0]    r_a;
    logic [SQ_W-1:0]            r_q;
    logic [D_W-1:0]             r_dmag;
    logic                       r_dneg;

    logic [SAMPLE_W-1:0]        w_abs;
    logic [SAMPLE_W/2-1:0]      w_root8;
    logic                       w_sgn;
    logic signed [ROOT_W-1:0]   w_s;
    logic [SAMPLE_W-1:0]        w_rsq;
    logic signed [D_W-1:0]      w_a_ext;
    logic signed [D_W-1:0]      w_diff;
    logic signed [D_W-1:0]      w_d;
    logic [D_W-1:0]             w_d_abs;
    logic [D_W/2-1:0]           w_droot;
    logic signed [OUT_W-1:0]    w_das_mean;
    logic signed [OUT_W-1:0]    w_dmas_out;
    logic [31:0]                w_unused_params;

    assign w_unused_params = 32'(pixels) ^ 32'(datasize);

    assign w_abs = rfdata[SAMPLE_W-1] ? SAMPLE_W'(-rfdata) : SAMPLE_W'(rfdata);

    isqrt_pipe #(.IN_W(SAMPLE_W), .LATENCY(L)) u_sample_root (
        .clk    (clk),
        .rst    (rst),
        .i_x    (r_abs),
        .o_root (w_root8)
    );

    // Sign rides alongside the root pipeline so it lines up with its root.
    assign w_sgn = r_sgn_dly[L-1];
    assign w_s   = w_sgn ? -$signed({1'b0, w_root8}) : $signed({1'b0, w_root8});
    assign w_rsq = {8'b0, w_root8} * {8'b0, w_root8};

    // Sum over i<j of s_i*s_j = (A^2 - sum s_i^2) / 2; the difference is always even.
    assign w_a_ext = D_W'(r_a);
    assign w_diff  = (w_a_ext * w_a_ext) - $signed(D_W'(r_q));
    assign w_d     = w_diff >>> 1;
    assign w_d_abs = w_d[D_W-1] ? D_W'(-w_d) : D_W'(w_d);

    isqrt_pipe #(.IN_W(D_W), .LATENCY(L)) u_final_root (
        .clk    (clk),
        .rst    (rst),
        .i_x    (r_dmag),
        .o_root (w_droot)
    );

    assign w_dmas_out = r_dneg ? -$signed({1'b0, w_droot}) : $signed({1'b0, w_droot});
    assign w_das_mean = OUT_W'(r_das_acc >>> (bit_size - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mode    <= MODE_DAS;
            r_das_acc <= '0;
            r_abs     <= '0;
            r_neg     <= 1'b0;
            r_sgn_dly <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_dmag    <= '0;
            r_dneg    <= 1'b0;
            bf_out    <= '0;
        end else begin
            if (r_cnt <= C_LOAD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == '0) begin
                r_mode <= mode_e'(mode);
            end
            r_abs     <= w_abs;
            r_neg     <= rfdata[SAMPLE_W-1];
            r_sgn_dly <= L'({r_sgn_dly, r_neg});
            if (r_cnt != '0 && r_cnt <= C_LAST_SAMPLE) begin
                r_das_acc <= r_das_acc + DAS_ACC_W'(rfdata);
            end
            if (r_cnt >= C_ACC_FIRST && r_cnt <= C_ACC_LAST) begin
                r_a <= r_a + SUM_W'(w_s);
                r_q <= r_q + SQ_W'(w_rsq);
            end
            if (r_cnt == C_COMBINE) begin
                r_dmag <= w_d_abs;
                r_dneg <= w_d[D_W-1];
            end
            // DAS mean is simply held in its accumulator until the common load edge.
            if (r_cnt == C_LOAD) begin
                bf_out <= (r_mode == MODE_DMAS) ? w_dmas_out : w_das_mean;
            end
        end
    end
endmodule

// File: tb/tb_mebra_core.sv
// Directed bench for mebra_core: a 4-channel instance driven from a vector
// table and a default 128-channel instance for full-scale and reset cases.
module tb_mebra_core;
    localparam int L       = 5;
    localparam int C_BIG   = 128;
    localparam int C_SMALL = 4;
    localparam int T_BIG   = C_BIG + 2 * L + 3;
    localparam int T_SMALL = C_SMALL + 2 * L + 3;

    typedef struct {
        string                name;
        logic                 m;
        bit                   toggle;
        logic signed [15:0]   x0, x1, x2, x3;
        logic signed [16:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_b = 1'b1, mode_b = 1'b0;
    logic signed [15:0] rf_b  = '0;
    logic signed [16:0] out_b;
    logic               rst_s = 1'b1, mode_s = 1'b0;
    logic signed [15:0] rf_s  = '0;
    logic signed [16:0] out_s;

    mebra_core dut_big (
        .clk    (clk),
        .rst    (rst_b),
        .mode   (mode_b),
        .rfdata (rf_b),
        .bf_out (out_b)
    );

    mebra_core #(
        .channels     (C_SMALL),
        .bit_size     (3),
        .pixels       (1),
        .datasize     (C_SMALL),
        .sqrt_latency (L)
    ) dut_small (
        .clk    (clk),
        .rst    (rst_s),
        .mode   (mode_s),
        .rfdata (rf_s),
        .bf_out (out_s)
    );

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [16:0]        exp_q[$];
    logic signed [15:0] samp [C_BIG];
    vec_t               vecs [10];

    function automatic vec_t mk(input string name, input logic m, input bit tg,
                                input logic signed [15:0] a, input logic signed [15:0] b,
                                input logic signed [15:0] c, input logic signed [15:0] d,
                                input logic signed [16:0] e);
        vec_t v;
        v.name = name; v.m = m; v.toggle = tg;
        v.x0 = a; v.x1 = b; v.x2 = c; v.x3 = d; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [16:0] act,
                         input logic signed [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit big, input logic r, input logic m, input logic signed [15:0] d);
        if (big) begin
            rst_b = r; mode_b = m; rf_b = d;
        end else begin
            rst_s = r; mode_s = m; rf_s = d;
        end
    endtask

    function automatic logic signed [16:0] dut_out(input bit big);
        return big ? out_b : out_s;
    endfunction

    // Reset, capture mode at edge 0, stream samp[] at edges 1..C, then check
    // bf_out just before, at and well after the load edge.
    task automatic run_frame(input string name, input bit big, input logic m, input bit toggle);
        int                 c;
        int                 t;
        logic               cur_m;
        logic signed [16:0] exp;
        c = big ? C_BIG : C_SMALL;
        t = big ? T_BIG : T_SMALL;
        cur_m = m;
        exp = exp_q.pop_front();
        @(negedge clk);
        drive(big, 1'b1, ~m, 16'($urandom));
        @(negedge clk);
        check({name, " reset"}, dut_out(big), 17'sd0);
        drive(big, 1'b0, m, 16'($urandom));
        for (int k = 0; k < c; k++) begin
            @(negedge clk);
            if (toggle) cur_m = ~cur_m;
            drive(big, 1'b0, cur_m, samp[k]);
        end
        repeat (t - c) begin
            @(negedge clk);
            if (toggle) cur_m = ~cur_m;
            drive(big, 1'b0, cur_m, 16'($urandom));
        end
        check({name, " before_load"}, dut_out(big), 17'sd0);
        @(negedge clk);
        drive(big, 1'b0, ~cur_m, 16'($urandom));
        check({name, " load"}, dut_out(big), exp);
        repeat (20) begin
            @(negedge clk);
            drive(big, 1'b0, $urandom_range(0, 1) == 1, 16'($urandom));
        end
        check({name, " hold"}, dut_out(big), exp);
    endtask

    initial begin
        vecs[0] = mk("das_100",      1'b0, 1'b0,  16'sd100,  16'sd100,  16'sd100,   16'sd100,   17'sd100);
        vecs[1] = mk("dmas_100",     1'b1, 1'b0,  16'sd100,  16'sd100,  16'sd100,   16'sd100,   17'sd24);
        vecs[2] = mk("das_m100",     1'b0, 1'b0, -16'sd100, -16'sd100, -16'sd100,  -16'sd100,  -17'sd100);
        vecs[3] = mk("dmas_m100",    1'b1, 1'b0, -16'sd100, -16'sd100, -16'sd100,  -16'sd100,   17'sd24);
        vecs[4] = mk("das_alt",      1'b0, 1'b0,  16'sd100, -16'sd100,  16'sd100,  -16'sd100,   17'sd0);
        vecs[5] = mk("dmas_alt",     1'b1, 1'b0,  16'sd100, -16'sd100,  16'sd100,  -16'sd100,  -17'sd14);
        vecs[6] = mk("das_floor",    1'b0, 1'b0,  16'sd1,    16'sd4,    16'sd9,    -16'sd16,   -17'sd1);
        vecs[7] = mk("dmas_mixed",   1'b1, 1'b0,  16'sd1,    16'sd4,    16'sd9,    -16'sd16,   -17'sd3);
        vecs[8] = mk("das_big_tg",   1'b0, 1'b1,  16'sd50,   16'sd200, -16'sd7,     16'sd32767, 17'sd8252);
        vecs[9] = mk("dmas_big_tg",  1'b1, 1'b1,  16'sd50,   16'sd200, -16'sd7,     16'sd32767, 17'sd59);

        drive(1'b1, 1'b1, 1'b0, 16'sd0);
        drive(1'b0, 1'b1, 1'b0, 16'sd0);
        repeat (3) @(negedge clk);
        check("big initial reset", out_b, 17'sd0);
        check("small initial reset", out_s, 17'sd0);

        for (int v = 0; v < 10; v++) begin
            samp[0] = vecs[v].x0; samp[1] = vecs[v].x1;
            samp[2] = vecs[v].x2; samp[3] = vecs[v].x3;
            exp_q.push_back(vecs[v].exp);
            run_frame(vecs[v].name, 1'b0, vecs[v].m, vecs[v].toggle);
        end

        for (int k = 0; k < C_BIG; k++) samp[k] = 16'sd0;
        exp_q.push_back(17'sd0);
        run_frame("zero_das", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(17'sd0);
        run_frame("zero_dmas", 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < C_BIG; k++) samp[k] = -16'sd32768;
        exp_q.push_back(-17'sd32768);
        run_frame("fullscale_das", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(17'sd16318);
        run_frame("fullscale_dmas", 1'b1, 1'b1, 1'b0);

        // Partial DMAS frame of 100s cut by reset at edge 50, then a clean frame.
        for (int k = 0; k < C_BIG; k++) samp[k] = 16'sd100;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'sd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 16'sd100);
        for (int k = 0; k < 49; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, samp[k]);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'sd100);
        @(negedge clk);
        check("midframe reset", out_b, 17'sd0);
        exp_q.push_back(17'sd901);
        run_frame("after_reset_dmas_tg", 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
